snax_csr_xlate_ordered: RTL and testbench
=========================================

Name: snax_csr_xlate_ordered

Overview:
- Parametrised successor to the SNAX accelerator-to-CSR translator.
- Converts the Snitch accelerator request/response ports into a simplified CSR request/response handshake.
- Tracks outstanding reads in an in-order ID FIFO, so every response carries the ID of the request that caused it.
- Range-checks CSR addresses and answers out-of-range reads locally with an error response, preserving order.

Parameters:
- DataWidth, 32, CSR data width.
- IdWidth, 5, width of the accelerator request/response ID.
- CsrAddrOffset, 32'h3c0, base CSR number subtracted from data_argb.
- NumCsr, 64, number of CSRs in the accelerator window (address range).
- MaxOutstanding, 4, ID FIFO depth (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- snax_req_data_op_i  in  32  offloaded instruction word
- snax_req_data_arga_i  in  DataWidth  write/set/clear operand
- snax_req_data_argb_i  in  32  CSR number
- snax_req_id_i  in  IdWidth  request ID
- snax_qvalid_i  in  1  request valid
- snax_qready_o  out  1  request ready
- snax_resp_data_o  out  DataWidth  response data
- snax_resp_id_o  out  IdWidth  response ID
- snax_resp_error_o  out  1  response error
- snax_pvalid_o  out  1  response valid
- snax_pready_i  in  1  response ready
- snax_csr_req_bits_data_o  out  DataWidth
- snax_csr_req_bits_addr_o  out  32  CSR index (argb - CsrAddrOffset)
- snax_csr_req_bits_write_o  out  1
- snax_csr_req_valid_o  out  1
- snax_csr_req_ready_i  in  1
- snax_csr_rsp_bits_data_i  in  DataWidth
- snax_csr_rsp_valid_i  in  1
- snax_csr_rsp_ready_o  out  1
- idle_o  out  1  FIFO empty

Behaviour:
- Op decode uses funct3 = data_op[14:12].
  - Read: funct3 in {010, 011, 110, 111} (CSRRS, CSRRC, CSRRSI, CSRRCI).
  - Write: every other funct3.
- Index = argb - CsrAddrOffset, 32-bit modular. in_range = (index < NumCsr), unsigned. Below-offset addresses wrap high and are out of range.
- Request path is combinational, zero latency. Data and addr pass through unconditionally.
  - In-range write: csr_req_valid_o = qvalid_i; qready_o = csr_req_ready_i; write_o = 1. No FIFO entry, no response.
  - In-range read: csr_req_valid_o = qvalid_i & ~full; qready_o = csr_req_ready_i & ~full; write_o = 0. On handshake, push {id, err=0}.
  - Out-of-range write: csr_req_valid_o = 0; qready_o = 1; request is dropped.
  - Out-of-range read: csr_req_valid_o = 0; qready_o = ~full. On handshake, push {id, err=1}.
- ID FIFO: depth MaxOutstanding, with registered read/write pointers (wrap at depth) and a count of clog2(MaxOutstanding+1) bits.
  - full = (count == MaxOutstanding); empty = (count == 0).
  - full is evaluated before any same-cycle pop: a push is refused when full even if a pop occurs that cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Response path, head entry H, valid when ~empty:
  - H.err = 0: pvalid_o = snax_csr_rsp_valid_i; csr_rsp_ready_o = pready_i; resp_data = csr_rsp_bits_data_i; error = 0.
  - H.err = 1: pvalid_o = 1; csr_rsp_ready_o = 0; resp_data = 0; error = 1. No CSR response is consumed.
  - resp_id_o = H.id.
  - Pop when pvalid_o & pready_i.
- FIFO empty: pvalid_o = 0, csr_rsp_ready_o = 0. An unsolicited CSR response is never accepted and stays stalled on the CSR side.
- idle_o = empty.
- Reset (rst_i high, sampled on the clk_i edge): pointers and count return to 0 and FIFO contents are discarded.
  - While rst_i is high, qready_o, csr_req_valid_o, pvalid_o and csr_rsp_ready_o are forced to 0 and idle_o = 1.
  - resp_data_o, resp_id_o and resp_error_o = 0 during reset.
  - Reset mid-transaction abandons outstanding IDs; any late CSR responses are then treated as unsolicited.

Optional Feature:
- Macro SNAX_CSR_XLATE_PERF_CNT_EN adds outputs perf_rd_cnt_o[31:0], perf_wr_cnt_o[31:0] and perf_err_cnt_o[31:0].
  - rd increments on each accepted read request; wr on each accepted in-range write; err on each accepted out-of-range request.
  - All three counters are cleared by rst_i and wrap at 2^32.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- In-range write, argb=0x3c5, arga=0xDEAD: csr addr=5, write=1, data=0xDEAD, same-cycle qready; no pvalid; idle stays 1.
- Read argb=0x3c2 with id=7; CSR responds 0x1234 three cycles later -> resp data=0x1234, id=7, error=0; FIFO returns empty.
- Four reads (ids 1-4) with CSR responses withheld -> fifth read sees qready=0 and csr_req_valid=0. After one response, resp id=1 and the fifth read is accepted the following cycle.
- Read argb=0x3c0+64 (id=9), then in-range read id=10 -> resp id=9 error=1 data=0 with no CSR rsp consumed, then id=10 after the CSR responds; in-order.
- argb=0x3bf write -> qready=1, csr_req_valid=0; counter err increments when the macro is defined.
- Two outstanding reads, then rst_i pulsed one cycle -> idle=1, pvalid=0; a subsequent CSR rsp_valid sees csr_rsp_ready=0.

Source files
------------

// File: rtl/snax_csr_xlate_ordered.sv
`default_nettype none
// ============================================================================
// Module   : snax_csr_xlate_ordered
// Brief    : Translates Snitch accelerator request/response ports into a
//            simple CSR request/response handshake. Outstanding reads are
//            tracked in an in-order ID FIFO so every response carries the ID
//            of its request; out-of-range reads are answered locally with an
//            error response that keeps its place in the response order.
// Options  : define SNAX_CSR_XLATE_PERF_CNT_EN to add read/write/error
//            performance counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module snax_csr_xlate_ordered #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter logic [31:0] CsrAddrOffset  = 32'h3c0,
  parameter int unsigned NumCsr         = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // accelerator request port
  input  logic [31:0]          snax_req_data_op_i,
  input  logic [DataWidth-1:0] snax_req_data_arga_i,
  input  logic [31:0]          snax_req_data_argb_i,
  input  logic [IdWidth-1:0]   snax_req_id_i,
  input  logic                 snax_qvalid_i,
  output logic                 snax_qready_o,
  // accelerator response port
  output logic [DataWidth-1:0] snax_resp_data_o,
  output logic [IdWidth-1:0]   snax_resp_id_o,
  output logic                 snax_resp_error_o,
  output logic                 snax_pvalid_o,
  input  logic                 snax_pready_i,
  // CSR request port
  output logic [DataWidth-1:0] snax_csr_req_bits_data_o,
  output logic [31:0]          snax_csr_req_bits_addr_o,
  output logic                 snax_csr_req_bits_write_o,
  output logic                 snax_csr_req_valid_o,
  input  logic                 snax_csr_req_ready_i,
  // CSR response port
  input  logic [DataWidth-1:0] snax_csr_rsp_bits_data_i,
  input  logic                 snax_csr_rsp_valid_i,
  output logic                 snax_csr_rsp_ready_o,
  // status
  output logic                 idle_o
`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_rd_cnt_o,
  output logic [31:0]          perf_wr_cnt_o,
  output logic [31:0]          perf_err_cnt_o
`endif
);

  localparam int unsigned PtrWidth   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
  localparam int unsigned EntryWidth = IdWidth + 1;
  localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(MaxOutstanding);
  localparam logic [31:0]         CsrLimit  = 32'(NumCsr);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [2:0]  funct3;
  logic        is_read;
  logic [31:0] csr_index;
  logic        in_range;

  assign funct3    = snax_req_data_op_i[14:12];
  // CSRRS/CSRRC and their immediate forms return data; everything else writes
  assign is_read   = funct3 inside {3'b010, 3'b011, 3'b110, 3'b111};
  // modular subtraction: addresses below the offset wrap high and fail the check
  assign csr_index = snax_req_data_argb_i - CsrAddrOffset;
  assign in_range  = (csr_index < CsrLimit);

  // only funct3 is decoded from the instruction word
  logic unused_op_bits;
  assign unused_op_bits = ^{snax_req_data_op_i[31:15], snax_req_data_op_i[11:0]};

  // ---------------------------------------------------------------------------
  // ID FIFO state; each entry is {error, id}
  // ---------------------------------------------------------------------------
  logic [EntryWidth-1:0] id_mem [MaxOutstanding];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [CntWidth-1:0]   count;
  logic                  full;
  logic                  empty;
  logic [EntryWidth-1:0] head;
  logic                  push;
  logic                  push_err;
  logic                  pop;

  assign full  = (count == FullCount);
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request path: zero-latency steering of valid/ready and FIFO push
  // ---------------------------------------------------------------------------
  logic q_ready;
  logic req_valid;

  // decide where the request goes and whether it needs an ordering slot
  always_comb begin
    q_ready   = 1'b0;
    req_valid = 1'b0;
    push      = 1'b0;
    push_err  = 1'b0;
    if (!rst_i) begin
      if (in_range) begin
        if (is_read) begin
          req_valid = snax_qvalid_i & ~full;
          q_ready   = snax_csr_req_ready_i & ~full;
        end else begin
          req_valid = snax_qvalid_i;
          q_ready   = snax_csr_req_ready_i;
        end
      end else begin
        // out-of-range writes are swallowed, reads still need a slot
        q_ready = is_read ? ~full : 1'b1;
      end
      push     = is_read & snax_qvalid_i & q_ready;
      push_err = ~in_range;
    end
  end

  assign snax_qready_o             = q_ready;
  assign snax_csr_req_valid_o      = req_valid;
  assign snax_csr_req_bits_data_o  = snax_req_data_arga_i;
  assign snax_csr_req_bits_addr_o  = csr_index;
  assign snax_csr_req_bits_write_o = ~is_read;

  // ---------------------------------------------------------------------------
  // Response path: head of the FIFO selects CSR pass-through or local error
  // ---------------------------------------------------------------------------
  logic                 resp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] resp_data;
  logic [IdWidth-1:0]   resp_id;
  logic                 resp_error;

  // build the response for the oldest outstanding read
  always_comb begin
    resp_valid = 1'b0;
    rsp_ready  = 1'b0;
    resp_data  = '0;
    resp_id    = '0;
    resp_error = 1'b0;
    if (!rst_i && !empty) begin
      resp_id = head[IdWidth-1:0];
      if (head[IdWidth]) begin
        // locally generated error, the CSR side is left untouched
        resp_valid = 1'b1;
        resp_error = 1'b1;
      end else begin
        resp_valid = snax_csr_rsp_valid_i;
        rsp_ready  = snax_pready_i;
        resp_data  = snax_csr_rsp_bits_data_i;
      end
    end
  end

  assign pop                  = resp_valid & snax_pready_i;
  assign snax_pvalid_o        = resp_valid;
  assign snax_csr_rsp_ready_o = rsp_ready;
  assign snax_resp_data_o     = resp_data;
  assign snax_resp_id_o       = resp_id;
  assign snax_resp_error_o    = resp_error;
  assign idle_o               = rst_i | empty;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------

  // advance pointers and occupancy; push is already gated by full
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // store the ID and error flag of each accepted read
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= {push_err, snax_req_id_i};
    end
  end

`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic        req_accept;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] err_cnt;

  assign req_accept = snax_qvalid_i & q_ready;

  // count accepted reads, in-range writes and out-of-range requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (req_accept && is_read) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (req_accept && !is_read && in_range) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
      if (req_accept && !in_range) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end

  assign perf_rd_cnt_o  = rd_cnt;
  assign perf_wr_cnt_o  = wr_cnt;
  assign perf_err_cnt_o = err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snax_csr_xlate_ordered.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_csr_xlate_ordered
// Brief    : Self-checking bench: directed scenarios plus random traffic,
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_csr_xlate_ordered;

  localparam int          IdW    = 5;
  localparam int          DW     = 32;
  localparam int          Depth  = 4;
  localparam int          NCsr   = 64;
  localparam logic [31:0] Offset = 32'h3c0;
  localparam logic [31:0] OpWr   = 32'h0000_1073;  // csrrw
  localparam logic [31:0] OpRd   = 32'h0000_2073;  // csrrs

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    op;
  logic [DW-1:0]  arga;
  logic [31:0]    argb;
  logic [IdW-1:0] req_id;
  logic           qvalid;
  logic           qready;
  logic [DW-1:0]  resp_data;
  logic [IdW-1:0] resp_id;
  logic           resp_err;
  logic           pvalid;
  logic           pready;
  logic [DW-1:0]  csr_data;
  logic [31:0]    csr_addr;
  logic           csr_write;
  logic           csr_req_valid;
  logic           csr_req_ready;
  logic [DW-1:0]  csr_rsp_data;
  logic           csr_rsp_valid;
  logic           csr_rsp_ready;
  logic           idle;
`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
  logic [31:0]    perf_rd, perf_wr, perf_err;
`endif

  always #5 clk = ~clk;

  snax_csr_xlate_ordered #(
    .DataWidth(DW), .IdWidth(IdW), .CsrAddrOffset(Offset),
    .NumCsr(NCsr), .MaxOutstanding(Depth)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .snax_req_data_op_i(op), .snax_req_data_arga_i(arga),
    .snax_req_data_argb_i(argb), .snax_req_id_i(req_id),
    .snax_qvalid_i(qvalid), .snax_qready_o(qready),
    .snax_resp_data_o(resp_data), .snax_resp_id_o(resp_id),
    .snax_resp_error_o(resp_err), .snax_pvalid_o(pvalid),
    .snax_pready_i(pready),
    .snax_csr_req_bits_data_o(csr_data), .snax_csr_req_bits_addr_o(csr_addr),
    .snax_csr_req_bits_write_o(csr_write), .snax_csr_req_valid_o(csr_req_valid),
    .snax_csr_req_ready_i(csr_req_ready),
    .snax_csr_rsp_bits_data_i(csr_rsp_data), .snax_csr_rsp_valid_i(csr_rsp_valid),
    .snax_csr_rsp_ready_o(csr_rsp_ready),
    .idle_o(idle)
`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
    , .perf_rd_cnt_o(perf_rd), .perf_wr_cnt_o(perf_wr), .perf_err_cnt_o(perf_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of outstanding reads {err, id}, checked each cycle
  // ---------------------------------------------------------------------------
  logic [IdW:0] model_q[$];
  logic [31:0]  m_rd = 0, m_wr = 0, m_err = 0;

  always @(negedge clk) begin : monitor
    logic [31:0]    idx;
    logic           rd_op, inr, full, empty, e_qr, e_rv, e_pv, e_cr;
    rd_op = op[14:12] inside {3'b010, 3'b011, 3'b110, 3'b111};
    idx   = argb - Offset;
    inr   = idx < NCsr;
    full  = (model_q.size() == Depth);
    empty = (model_q.size() == 0);
    if (rst) begin
      check("rst_qready", qready, 0);
      check("rst_req_valid", csr_req_valid, 0);
      check("rst_pvalid", pvalid, 0);
      check("rst_rsp_ready", csr_rsp_ready, 0);
      check("rst_idle", idle, 1);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_err", resp_err, 0);
      model_q.delete();
      m_rd = 0; m_wr = 0; m_err = 0;
    end else begin
      // request side: a read needs a free slot, an in-range access needs the CSR
      e_qr = (!inr || csr_req_ready) && !(rd_op && full);
      e_rv = inr && qvalid && !(rd_op && full);
      check("qready", qready, e_qr);
      check("req_valid", csr_req_valid, e_rv);
      check("req_addr", csr_addr, idx);
      check("req_data", csr_data, arga);
      check("req_write", csr_write, !rd_op);
      // response side: oldest outstanding read is answered first
      if (empty) begin
        e_pv = 0; e_cr = 0;
      end else if (model_q[0][IdW]) begin
        e_pv = 1; e_cr = 0;
      end else begin
        e_pv = csr_rsp_valid; e_cr = pready;
      end
      check("pvalid", pvalid, e_pv);
      check("rsp_ready", csr_rsp_ready, e_cr);
      check("idle", idle, empty);
      if (e_pv) begin
        check("resp_id", resp_id, model_q[0][IdW-1:0]);
        check("resp_err", resp_err, model_q[0][IdW]);
        check("resp_data", resp_data, model_q[0][IdW] ? '0 : csr_rsp_data);
      end
`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
      check("perf_rd", perf_rd, m_rd);
      check("perf_wr", perf_wr, m_wr);
      check("perf_err", perf_err, m_err);
`endif
      if (e_pv && pready) void'(model_q.pop_front());
      if (qvalid && e_qr) begin
        if (rd_op) begin
          model_q.push_back({!inr, req_id});
          m_rd++;
        end else if (inr) begin
          m_wr++;
        end
        if (!inr) m_err++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1; op = OpWr; arga = 0; argb = Offset; req_id = 0; qvalid = 0;
    csr_req_ready = 1; csr_rsp_data = 0; csr_rsp_valid = 0; pready = 1;
    repeat (3) step();
    check("reset_idle", idle, 1);
    rst = 0;
    step();

    // in-range write
    op = OpWr; argb = 32'h3c5; arga = 32'hDEAD; qvalid = 1;
    #1;
    check("wr_addr", csr_addr, 5);
    check("wr_write", csr_write, 1);
    check("wr_data", csr_data, 32'hDEAD);
    check("wr_qready", qready, 1);
    check("wr_pvalid", pvalid, 0);
    step();
    qvalid = 0;
    #1 check("wr_idle", idle, 1);

    // single read with delayed CSR response
    op = OpRd; argb = 32'h3c2; req_id = 7; qvalid = 1;
    #1 check("rd_req_valid", csr_req_valid, 1);
    step();
    qvalid = 0;
    step(); step();
    csr_rsp_valid = 1; csr_rsp_data = 32'h1234;
    #1;
    check("rd_pvalid", pvalid, 1);
    check("rd_data", resp_data, 32'h1234);
    check("rd_id", resp_id, 7);
    check("rd_err", resp_err, 0);
    step();
    csr_rsp_valid = 0;
    #1 check("rd_idle", idle, 1);

    // fill the FIFO, fifth read must stall until a slot frees up
    for (int i = 1; i <= 4; i++) begin
      op = OpRd; argb = Offset + 32'(i); req_id = 5'(i); qvalid = 1;
      step();
    end
    req_id = 5;
    #1;
    check("full_qready", qready, 0);
    check("full_req_valid", csr_req_valid, 0);
    step();
    csr_rsp_valid = 1; csr_rsp_data = 32'hA1;
    #1;
    check("full_resp_id", resp_id, 1);
    check("full_pop_qready", qready, 0);
    step();
    csr_rsp_valid = 0;
    #1 check("after_pop_qready", qready, 1);
    step();
    qvalid = 0;
    for (int i = 0; i < 4; i++) begin
      csr_rsp_valid = 1; csr_rsp_data = 32'hB0 + 32'(i);
      #1 check("drain_id", resp_id, 5'(2 + i));
      step();
    end
    csr_rsp_valid = 0;
    #1 check("drain_idle", idle, 1);

    // out-of-range read followed by an in-range read keeps order
    op = OpRd; argb = Offset + 32'd64; req_id = 9; qvalid = 1;
    #1;
    check("oor_req_valid", csr_req_valid, 0);
    check("oor_qready", qready, 1);
    step();
    argb = 32'h3c1; req_id = 10; csr_rsp_valid = 1; csr_rsp_data = 32'hBEEF;
    #1;
    check("oor_resp_id", resp_id, 9);
    check("oor_resp_err", resp_err, 1);
    check("oor_resp_data", resp_data, 0);
    check("oor_rsp_ready", csr_rsp_ready, 0);
    step();
    qvalid = 0;
    #1;
    check("ord_resp_id", resp_id, 10);
    check("ord_resp_data", resp_data, 32'hBEEF);
    check("ord_resp_err", resp_err, 0);
    step();
    csr_rsp_valid = 0;

    // write below the window is dropped
    op = OpWr; argb = 32'h3bf; qvalid = 1;
    #1;
    check("low_qready", qready, 1);
    check("low_req_valid", csr_req_valid, 0);
`ifdef SNAX_CSR_XLATE_PERF_CNT_EN
    begin
      logic [31:0] err_before;
      err_before = perf_err;
      step();
      #1 check("low_err_cnt", perf_err, err_before + 32'd1);
    end
`else
    step();
`endif
    qvalid = 0;

    // reset with reads outstanding
    op = OpRd; argb = 32'h3c3; req_id = 11; qvalid = 1;
    step();
    req_id = 12;
    step();
    qvalid = 0; rst = 1;
    #1;
    check("mid_rst_idle", idle, 1);
    check("mid_rst_qready", qready, 0);
    step();
    rst = 0; csr_rsp_valid = 1; csr_rsp_data = 32'h55;
    #1;
    check("post_rst_idle", idle, 1);
    check("post_rst_pvalid", pvalid, 0);
    check("post_rst_rsp_ready", csr_rsp_ready, 0);
    step();
    csr_rsp_valid = 0;

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      op = $urandom;
      argb = ($urandom_range(0, 15) == 0) ? 32'($urandom)
                                          : Offset + 32'($urandom_range(0, 71)) - 32'd4;
      arga = $urandom;
      req_id = 5'($urandom);
      qvalid = 1'($urandom_range(0, 1));
      csr_req_ready = ($urandom_range(0, 3) != 0);
      csr_rsp_valid = 1'($urandom_range(0, 1));
      csr_rsp_data = $urandom;
      pready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0; qvalid = 0; csr_rsp_valid = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
